enc32to5_serializer: RTL and testbench
======================================

// Module: enc32to5_serializer
// PURPOSE
//  Inverse partner of the 5-to-32 decoder: accepts a 32-bit request vector and emits
//  the 5-bit index of every set bit, one index per accepted handshake, in priority order.
//  Converts multi-hot status words into a stream of binary indices. Sits between
//  interrupt/request collectors and index-driven consumers such as a dec5to32 select path.
// PARAMETERS
//  WIDTH      32  input vector width; WIDTH = 2**IDX_W
//  IDX_W      5   index width
//  MSB_FIRST  0   0: lowest set bit emitted first; 1: highest set bit emitted first
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous reset, active low
//  in_vec     in   WIDTH  request vector, sampled on input handshake
//  in_valid   in   1      in_vec valid
//  in_ready   out  1      block can accept a vector (high only in IDLE)
//  idx        out  IDX_W  index of current priority set bit in pending register
//  idx_valid  out  1      idx valid (high only in DRAIN)
//  idx_ready  in   1      consumer accepts idx
//  idx_last   out  1      current idx is the final set bit of the vector
//  zero_flag  out  1      one-cycle pulse: all-zero vector was accepted and dropped
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, pending=0, zero_flag=0. Outputs after reset:
//  in_ready=1, idx_valid=0, idx=0, idx_last=0. Reset mid-DRAIN discards remaining bits.
//  State machine (2 states):
//   IDLE : in_ready=1. On in_valid&&in_ready: nonzero vec -> pending<=in_vec, go DRAIN;
//          zero vec -> stay IDLE, zero_flag=1 for the following cycle only.
//   DRAIN: in_ready=0, idx_valid=1. idx = lowest (MSB_FIRST=0) or highest (MSB_FIRST=1)
//          set bit of pending, combinational from pending. idx_last=1 iff exactly one bit set.
//          On idx_ready: clear that bit of pending; if idx_last -> go IDLE, else stay.
//          With idx_ready=0, idx/idx_valid/idx_last hold stable (no change in pending).
//  Latency: vector accepted at edge N -> first idx_valid at cycle after N. k set bits
//  drain in exactly k cycles with idx_ready held high; in_ready returns 1 the cycle after
//  the last index handshake (no same-cycle reload; one bubble per vector).
//  in_vec/in_valid ignored while in DRAIN. Bit WIDTH-1 yields idx=WIDTH-1 (5'd31), no wrap.
//  All-ones vector emits 0..31 (or 31..0), idx_last only on the 32nd.
//  zero_flag and state updates are registered; idx/idx_last are decode of registered pending.
// CONFIGURATION
//  ENC_CNT_EN defined: adds output port pend_cnt [IDX_W:0] = popcount(pending), 0 in IDLE
//   and after reset, 32 right after accepting all-ones, decrements by 1 per idx handshake.
//  ENC_CNT_EN undefined: port and popcount logic absent; all other behaviour identical.
// TESTING
//  1 rst_n=0 two cycles, then 1 -> in_ready=1, idx_valid=0, zero_flag=0, (pend_cnt=0).
//  2 in_vec=32'h0000_0001 accepted, idx_ready=1 -> one idx=0 with idx_last=1; in_ready=1 next cycle.
//  3 in_vec=32'h8000_0011, MSB_FIRST=0, idx_ready=1 -> idx 0,4,31 on consecutive cycles; idx_last on 31.
//  4 same vector, idx_ready toggled 1,0,0,1,1 -> idx holds 4 through stall; total 3 handshakes; in_vec changes during DRAIN ignored.
//  5 in_vec=32'h0 accepted -> zero_flag high exactly one cycle, state stays IDLE, idx_valid=0.
//  6 in_vec=32'hFFFF_FFFF, MSB_FIRST=1, rst_n=0 after 3 handshakes (idx 31,30,29) -> IDLE, idx_valid=0 next cycle.

Source files
------------

// File: rtl/enc32to5_serializer.sv
// Serializes a multi-hot request vector into a stream of set-bit indices, one per handshake.
// Optional ENC_CNT_EN adds pend_cnt, the popcount of the bits still to be emitted.
module enc32to5_serializer #(
  parameter int WIDTH     = 32,
  parameter int IDX_W     = 5,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic             idx_last,
`ifdef ENC_CNT_EN
  output logic [IDX_W:0]   pend_cnt,
`endif
  output logic             zero_flag
);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pending_q, pending_d;
  logic               zero_flag_q, zero_flag_d;

  logic [IDX_W-1:0]   sel_idx;
  logic [WIDTH-1:0]   sel_hot;
  logic               single_bit;

  // Priority pick: the last match in loop order wins, so loop direction sets priority.
  always_comb begin
    sel_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (pending_q[i]) sel_idx = IDX_W'(i);
    end else begin
      for (int i = WIDTH-1; i >= 0; i--)
        if (pending_q[i]) sel_idx = IDX_W'(i);
    end
  end

  assign sel_hot    = WIDTH'(1) << sel_idx;
  assign single_bit = (pending_q != '0) &&
                      ((pending_q & (pending_q - WIDTH'(1))) == '0);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    zero_flag_d = 1'b0;
    in_ready    = 1'b0;
    idx_valid   = 1'b0;
    idx         = '0;
    idx_last    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_vec != '0) begin
            pending_d = in_vec;
            state_d   = S_DRAIN;
          end else begin
            zero_flag_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        idx_valid = 1'b1;
        idx       = sel_idx;
        idx_last  = single_bit;
        if (idx_ready) begin
          pending_d = pending_q & ~sel_hot;
          if (single_bit) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      zero_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      zero_flag_q <= zero_flag_d;
    end
  end

  assign zero_flag = zero_flag_q;

`ifdef ENC_CNT_EN
  // pending is cleared on the final handshake, so the count reads 0 in IDLE.
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < WIDTH; i++)
      pend_cnt = pend_cnt + {{IDX_W{1'b0}}, pending_q[i]};
  end
`endif

endmodule

// File: tb/tb_enc32to5_serializer.sv
// Directed bench: two instances (LSB-first and MSB-first) share one stimulus stream.
module tb_enc32to5_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_vec;
  logic        in_valid;
  logic        idx_ready;

  logic        in_ready_l, idx_valid_l, idx_last_l, zero_flag_l;
  logic [4:0]  idx_l;
  logic        in_ready_m, idx_valid_m, idx_last_m, zero_flag_m;
  logic [4:0]  idx_m;
`ifdef ENC_CNT_EN
  logic [5:0]  cnt_l, cnt_m;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int hs     = 0;

  always #5 clk = ~clk;

  enc32to5_serializer #(.WIDTH(32), .IDX_W(5), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(in_ready_l), .idx(idx_l), .idx_valid(idx_valid_l),
    .idx_ready(idx_ready), .idx_last(idx_last_l),
`ifdef ENC_CNT_EN
    .pend_cnt(cnt_l),
`endif
    .zero_flag(zero_flag_l)
  );

  enc32to5_serializer #(.WIDTH(32), .IDX_W(5), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(in_ready_m), .idx(idx_m), .idx_valid(idx_valid_m),
    .idx_ready(idx_ready), .idx_last(idx_last_m),
`ifdef ENC_CNT_EN
    .pend_cnt(cnt_m),
`endif
    .zero_flag(zero_flag_m)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    if (idx_valid_l && idx_ready) hs++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_vec = '0; in_valid = 1'b0; idx_ready = 1'b0;

    // 1: reset
    step(); step();
    chk("rst_in_ready",  in_ready_l,  1);
    chk("rst_idx_valid", idx_valid_l, 0);
    chk("rst_zero_flag", zero_flag_l, 0);
    chk("rst_idx",       idx_l,       0);
    chk("rst_idx_last",  idx_last_l,  0);
`ifdef ENC_CNT_EN
    chk("rst_cnt", cnt_l, 0);
`endif
    rst_n = 1'b1;

    // 2: single bit 0
    in_vec = 32'h0000_0001; in_valid = 1'b1; idx_ready = 1'b1;
    step(); in_valid = 1'b0;
    chk("t2_valid",    idx_valid_l, 1);
    chk("t2_idx",      idx_l,       0);
    chk("t2_last",     idx_last_l,  1);
    chk("t2_in_ready", in_ready_l,  0);
    step();
    chk("t2_back_idle", in_ready_l,  1);
    chk("t2_no_valid",  idx_valid_l, 0);

    // 3: 0x8000_0011 -> LSB 0,4,31 / MSB 31,4,0
    in_vec = 32'h8000_0011; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    chk("t3_idx0",  idx_l, 0);  chk("t3_last0", idx_last_l, 0);
    chk("t3_m_idx0", idx_m, 31);
`ifdef ENC_CNT_EN
    chk("t3_cnt", cnt_l, 3);
`endif
    step();
    chk("t3_idx1",  idx_l, 4);  chk("t3_last1", idx_last_l, 0);
    chk("t3_m_idx1", idx_m, 4);
    step();
    chk("t3_idx2",  idx_l, 31); chk("t3_last2", idx_last_l, 1);
    chk("t3_m_idx2", idx_m, 0); chk("t3_m_last2", idx_last_m, 1);
    step();
    chk("t3_idle", in_ready_l, 1);

    // 4: stall pattern 1,0,0,1,1 with in_vec churn during DRAIN
    in_vec = 32'h8000_0011; in_valid = 1'b1;
    step();
    hs = 0;
    idx_ready = 1'b1;
    chk("t4_c0", idx_l, 0);
    step();
    idx_ready = 1'b0; in_vec = 32'h0000_FF00;
    chk("t4_c1", idx_l, 4);
    step();
    in_vec = 32'h1234_5678;
    chk("t4_c2", idx_l, 4); chk("t4_c2_valid", idx_valid_l, 1);
    step();
    idx_ready = 1'b1;
    chk("t4_c3", idx_l, 4);
    step();
    in_valid = 1'b0;
    chk("t4_c4", idx_l, 31); chk("t4_c4_last", idx_last_l, 1);
    step();
    chk("t4_hs",   hs, 3);
    chk("t4_idle", in_ready_l, 1);

    // 5: zero vector dropped
    in_vec = 32'h0; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    chk("t5_zf",    zero_flag_l, 1);
    chk("t5_ready", in_ready_l,  1);
    chk("t5_valid", idx_valid_l, 0);
    step();
    chk("t5_zf_gone", zero_flag_l, 0);
    chk("t5_valid2",  idx_valid_l, 0);

    // all-ones full drain: 32 indices, last only on the 32nd
    in_vec = 32'hFFFF_FFFF; in_valid = 1'b1;
    step(); in_valid = 1'b0;
`ifdef ENC_CNT_EN
    chk("ones_cnt", cnt_l, 32);
`endif
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("ones_idx%0d", i),  idx_l, i);
      chk($sformatf("ones_last%0d", i), idx_last_l, (i == 31) ? 1 : 0);
      chk($sformatf("ones_m%0d", i),    idx_m, 31 - i);
      step();
    end
    chk("ones_idle", in_ready_l, 1);

    // 6: reset mid-DRAIN after three handshakes
    in_vec = 32'hFFFF_FFFF; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    chk("t6_m0", idx_m, 31);
`ifdef ENC_CNT_EN
    chk("t6_cnt0", cnt_m, 32);
`endif
    step();
    chk("t6_m1", idx_m, 30);
`ifdef ENC_CNT_EN
    chk("t6_cnt1", cnt_m, 31);
`endif
    step();
    chk("t6_m2", idx_m, 29);
    step();
    chk("t6_m3", idx_m, 28);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_valid", idx_valid_m, 0);
    chk("t6_ready", in_ready_m,  1);
    chk("t6_idx",   idx_m,       0);
`ifdef ENC_CNT_EN
    chk("t6_cnt", cnt_m, 0);
`endif
    step();
    chk("t6_still_idle", idx_valid_m, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
